// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctl.sv
// firebird7_in_gate1_tessent_tdr_mux_ctl: IJTAG TDR that drives a data mux select/data
// pair with make-before-break select sequencing.  Revision 1.0
`default_nettype none

module firebird7_in_gate1_tessent_tdr_mux_ctl #(
  parameter int WIDTH = 3
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select_out
);

  typedef enum logic [3:0] {
    ST_OFF  = 4'b0001,
    ST_ARM  = 4'b0010,
    ST_ON   = 4'b0100,
    ST_DROP = 4'b1000
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_sr;
  logic [WIDTH:0]   r_pend;
  logic             r_pend_vld;

  logic             w_upd;
  logic             w_evt_vld;
  logic [WIDTH:0]   w_evt;

  assign ijtag_so  = r_sr[0];
  assign w_upd     = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
  // A fresh update takes precedence over one deferred from ARM/DROP.
  assign w_evt_vld = w_upd | r_pend_vld;
  assign w_evt     = w_upd ? r_sr : r_pend;

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_sr             <= '0;
      r_pend           <= '0;
      r_pend_vld       <= 1'b0;
      ijtag_data_out   <= '0;
      ijtag_select_out <= 1'b0;
      r_state          <= ST_OFF;
    end else begin
      if (ijtag_sel) begin
        if (ijtag_ce) begin
          r_sr <= {capture_data_in, ijtag_select_out};
        end else if (ijtag_se) begin
          r_sr <= {ijtag_si, r_sr[WIDTH:1]};
        end
      end

      case (r_state)
        ST_OFF: begin
          r_pend_vld <= 1'b0;
          if (w_evt_vld) begin
            ijtag_data_out <= w_evt[WIDTH:1];
            if (w_evt[0]) begin
              r_state <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          ijtag_select_out <= 1'b1;
          r_state          <= ST_ON;
          if (w_upd) begin
            r_pend     <= r_sr;
            r_pend_vld <= 1'b1;
          end
        end
        ST_ON: begin
          r_pend_vld <= 1'b0;
          if (w_evt_vld) begin
            if (w_evt[0]) begin
              ijtag_data_out <= w_evt[WIDTH:1];
            end else begin
              ijtag_select_out <= 1'b0;
              r_state          <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          r_state <= ST_OFF;
          if (w_upd) begin
            r_pend     <= r_sr;
            r_pend_vld <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_OFF;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
